sync_fifo_ctrl: RTL
===================

Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO with data width, depth (non-power-of-2 allowed) and read mode (standard or first-word-fall-through) selectable at elaboration. It adds fill level, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. It serves as the same-clock-domain buffer alongside the team's dual-clock FIFO, for datapaths where both sides share one clock.

Parameters:
DATA_WIDTH, 32, width of wdata/rdata in bits (>=1)
DEPTH, 8, number of entries (>=2, any integer)
FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through
AF_THRESH, DEPTH-1, almost_full asserted when level >= AF_THRESH (legal range 1..DEPTH)
AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH (legal range 0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of FIFO contents and error flags
wr_en  input  1  write request
wdata  input  DATA_WIDTH  write data
full  output  1  level == DEPTH
almost_full  output  1  level >= AF_THRESH
rd_en  input  1  read request (standard) / pop of head entry (FWFT)
rdata  output  DATA_WIDTH  read data
rvalid  output  1  rdata qualifier
empty  output  1  level == 0
almost_empty  output  1  level <= AE_THRESH
level  output  $clog2(DEPTH)+1  current number of stored entries
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, level = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
  - Storage array contents are not reset.
- Accept rules are evaluated against registered state at the clock edge:
  - wr_acc = wr_en & ~full & ~flush.
  - rd_acc = rd_en & ~empty & ~flush.
- Write: on wr_acc, mem[wr_ptr] <= wdata and wr_ptr advances.
- Read pointer: on rd_acc, rd_ptr advances.
- Pointer wrap: binary, modulo DEPTH (DEPTH-1 -> 0). No power-of-2 restriction.
- Level update: level_next = level + wr_acc - rd_acc. Simultaneous accepted read and write leaves level unchanged.
- Flags: full, empty, almost_full and almost_empty are combinational compares of registered level, so they are valid in the same cycle as level.
- Full with wr_en & rd_en: the read is accepted and the write is dropped (overflow set). level goes to DEPTH-1.
- Empty with wr_en & rd_en: the write is accepted and the read is rejected (underflow set). level goes to 1.
- Error flags:
  - overflow <= 1 on wr_en & full & ~flush.
  - underflow <= 1 on rd_en & empty & ~flush.
  - Both hold until flush or rst.
- FWFT=0:
  - On rd_acc, rdata <= mem[rd_ptr] at that edge, and rvalid = 1 for exactly the following cycle. Latency rd_en -> rdata is 1 cycle.
  - Otherwise rvalid = 0 and rdata holds its last value.
- FWFT=1:
  - rdata = mem[rd_ptr] and rvalid = ~empty, continuously.
  - rd_en pops the head entry; the next entry (if any) is presented in the following cycle.
  - A write into an empty FIFO is visible on rdata with rvalid = 1 one cycle after wr_en.
- Flush:
  - Has priority over wr_en and rd_en in the same cycle.
  - Next cycle: wr_ptr = rd_ptr = 0, level = 0, overflow = underflow = 0, and rvalid = 0 in FWFT=0.
  - rdata is held in FWFT=0. Storage contents are untouched.
- Reset mid-operation: all registers return immediately (asynchronously) to reset values; in-flight reads are lost.
- Parameter violations (DEPTH < 2, thresholds out of range) are rejected at elaboration.

Test Plan:
- Basic ordering (DEPTH=8, FWFT=0): write 0x11..0x88 on 8 cycles, then read 8 -> full=1 after the 8th write; rdata = 0x11..0x88 in order, each one cycle after its rd_en with rvalid pulsed; empty=1 and level=0 at the end.
- Thresholds (AF_THRESH=6, AE_THRESH=2): write 6 entries -> almost_empty deasserts at level 3 and almost_full asserts at level 6; read 1 -> almost_full=0 at level 5.
- Boundary collisions:
  - Fill to 8, then wr_en & rd_en together -> level=7, overflow=1, the head word is read out, and the new word is absent.
  - From empty, wr_en & rd_en together -> level=1, underflow=1, rvalid=0.
- Wrap with DEPTH=5: push/pop 13 words with level held between 1 and 4 -> data order preserved across pointer wrap; no spurious full or empty.
- FWFT=1: write 0xA5 into empty FIFO -> the next cycle rdata=0xA5 and rvalid=1 with no rd_en; rd_en pops it and rvalid falls the following cycle.
- Flush and reset: with level=4 and overflow=1, assert flush together with wr_en -> next cycle level=0, empty=1, overflow=0, and no write occurs. Assert rst asynchronously mid-stream -> all outputs take reset values before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl
// Brief    : Single-clock FIFO with level, almost-full/empty thresholds,
//            sticky overflow/underflow, synchronous flush, optional FWFT.
// Revision : 1.0
// ============================================================================
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    full,
    output logic                    almost_full,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    empty,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_ctrl: DEPTH must be >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo_ctrl: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_ctrl: AE_THRESH must be in 0..DEPTH-1");
        end
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_ctrl: DATA_WIDTH must be >= 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full         = (level == FULL_LVL);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head is presented directly; gated so an empty FIFO shows zero.
            assign rdata  = empty ? '0 : mem[rd_ptr];
            assign rvalid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= mem[rd_ptr];
                    end
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule
`default_nettype wire
